pc_fft2d_sequencer: RTL and testbench

- Top-level sequencer for the floating-point phase-correlation pipeline.
- Runs one frame end to end, in this order:
  - 2D FFT of image A, as row pass then column pass.
  - 2D FFT of image B.
  - Cross-power-spectrum (CPS) unit.
  - 2D inverse FFT.
  - Peak search, which produces Out_Row/Out_Col.
- Shares the single 1D FFT core across all passes by issuing one line (row or column) at a time over a start/done handshake.

---
 rtl/pc_fft2d_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pc_fft2d_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fft2d_sequencer.sv
// rtl/pc_fft2d_sequencer.sv - phase-correlation frame sequencer sharing one 1D FFT core (optional PC_WATCHDOG_EN)
module pc_fft2d_sequencer #(
    parameter int N     = 128,
    parameter int LOG2N = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       phase,
    output logic             fft_start,
    output logic             fft_inverse,
    output logic             fft_col,
    output logic             fft_buf,
    output logic [LOG2N-1:0] line_idx,
    input  logic             fft_done,
    output logic             cps_start,
    input  logic             cps_done,
    output logic             peak_start,
    input  logic             peak_done,
    output logic [15:0]      frame_cnt
`ifdef PC_WATCHDOG_EN
    ,
    output logic             timeout
`endif
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_A_ROW = 4'd1,
        S_A_COL = 4'd2,
        S_B_ROW = 4'd3,
        S_B_COL = 4'd4,
        S_CPS   = 4'd5,
        S_I_ROW = 4'd6,
        S_I_COL = 4'd7,
        S_PEAK  = 4'd8,
        S_FIN   = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] line_q, line_d;
    logic             issue_q, issue_d;
    logic             entry_q;
    logic [15:0]      frame_q;
    logic             line_done;
    logic             last_line;

    function automatic logic is_fft(input state_t s);
        return (s == S_A_ROW) || (s == S_A_COL) || (s == S_B_ROW) ||
               (s == S_B_COL) || (s == S_I_ROW) || (s == S_I_COL);
    endfunction

    // A done in the same cycle as its own start cannot belong to that line
    assign line_done = is_fft(state_q) && fft_done && !issue_q;
    assign last_line = (line_q == LOG2N'(N - 1));

`ifdef PC_WATCHDOG_EN
    logic [19:0] wd_q, wd_d;
    logic        timeout_q;
    logic        waiting;
    logic        handshake;
    logic        wd_trip;

    assign waiting   = (state_q != S_IDLE) && (state_q != S_FIN);
    assign handshake = fft_start || fft_done || cps_start || cps_done ||
                       peak_start || peak_done;
    assign wd_trip   = waiting && !handshake && (wd_q == 20'hFFFFF);
`endif

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        issue_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_A_ROW;
                    line_d  = '0;
                    issue_d = 1'b1;
                end
            end
            S_A_ROW, S_A_COL, S_B_ROW, S_B_COL, S_I_ROW, S_I_COL: begin
                if (line_done) begin
                    if (last_line) begin
                        line_d = '0;
                        case (state_q)
                            S_A_ROW: state_d = S_A_COL;
                            S_A_COL: state_d = S_B_ROW;
                            S_B_ROW: state_d = S_B_COL;
                            S_B_COL: state_d = S_CPS;
                            S_I_ROW: state_d = S_I_COL;
                            default: state_d = S_PEAK;
                        endcase
                        issue_d = is_fft(state_d);
                    end else begin
                        line_d  = line_q + LOG2N'(1);
                        issue_d = 1'b1;
                    end
                end
            end
            S_CPS: begin
                if (cps_done) begin
                    state_d = S_I_ROW;
                    issue_d = 1'b1;
                end
            end
            S_PEAK: begin
                if (peak_done) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef PC_WATCHDOG_EN
        if (wd_trip) begin
            state_d = S_FIN;
            line_d  = '0;
            issue_d = 1'b0;
        end
`endif
    end

`ifdef PC_WATCHDOG_EN
    always_comb begin
        wd_d = wd_q + 20'd1;
        if (!waiting || handshake || (state_d != state_q)) wd_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (state_q == S_IDLE && start) timeout_q <= 1'b0;
            else if (wd_trip)               timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            issue_q <= 1'b0;
            entry_q <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            issue_q <= issue_d;
            entry_q <= (state_d != state_q);
`ifdef PC_WATCHDOG_EN
            // an aborted frame still reports done but is not counted
            if (state_q == S_FIN && !timeout_q) frame_q <= frame_q + 16'd1;
`else
            if (state_q == S_FIN) frame_q <= frame_q + 16'd1;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign phase       = state_q;
    assign fft_start   = issue_q;
    assign line_idx    = line_q;
    assign fft_col     = (state_q == S_A_COL) || (state_q == S_B_COL) || (state_q == S_I_COL);
    assign fft_buf     = (state_q == S_B_ROW) || (state_q == S_B_COL);
    assign fft_inverse = (state_q == S_I_ROW) || (state_q == S_I_COL);
    assign cps_start   = entry_q && (state_q == S_CPS);
    assign peak_start  = entry_q && (state_q == S_PEAK);
    assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_pc_fft2d_sequencer.sv
// tb/tb_pc_fft2d_sequencer.sv - directed self-checking bench for pc_fft2d_sequencer (N=4)
module tb_pc_fft2d_sequencer;
    localparam int N     = 4;
    localparam int LOG2N = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy, done, fft_start, fft_inverse, fft_col, fft_buf;
    logic             cps_start, peak_start;
    logic [3:0]       phase;
    logic [LOG2N-1:0] line_idx;
    logic [15:0]      frame_cnt;
    logic             fft_done, cps_done, peak_done;
`ifdef PC_WATCHDOG_EN
    logic             timeout;
`endif

    logic resp_fft = 1'b0, resp_cps = 1'b0, resp_peak = 1'b0;
    logic man_fft = 1'b0, man_cps = 1'b0, man_peak = 1'b0;
    logic auto_en = 1'b0;

    assign fft_done  = resp_fft | man_fft;
    assign cps_done  = resp_cps | man_cps;
    assign peak_done = resp_peak | man_peak;

    pc_fft2d_sequencer #(.N(N), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .phase(phase), .fft_start(fft_start), .fft_inverse(fft_inverse),
        .fft_col(fft_col), .fft_buf(fft_buf), .line_idx(line_idx),
        .fft_done(fft_done), .cps_start(cps_start), .cps_done(cps_done),
        .peak_start(peak_start), .peak_done(peak_done), .frame_cnt(frame_cnt)
`ifdef PC_WATCHDOG_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [4:0] log_q[$];
    int n_cps = 0, n_peak = 0, n_done = 0;
    // expected {col,buf,inv} for the six FFT passes in frame order
    logic [2:0] tbl [6] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101};

    always @(negedge clk) begin
        if (fft_start)  log_q.push_back({fft_col, fft_buf, fft_inverse, line_idx});
        if (cps_start)  n_cps++;
        if (peak_start) n_peak++;
        if (done)       n_done++;
    end

    // core model: fft_done 3 cycles after fft_start, cps/peak done 2 cycles after start
    initial begin
        int cd_f, cd_c, cd_p;
        cd_f = 0; cd_c = 0; cd_p = 0;
        forever begin
            @(posedge clk); #1;
            resp_fft = 1'b0; resp_cps = 1'b0; resp_peak = 1'b0;
            if (!rst_n || !auto_en) begin cd_f = 0; cd_c = 0; cd_p = 0; end
            if (cd_f > 0) begin cd_f--; if (cd_f == 0) resp_fft = 1'b1; end
            if (cd_c > 0) begin cd_c--; if (cd_c == 0) resp_cps = 1'b1; end
            if (cd_p > 0) begin cd_p--; if (cd_p == 0) resp_peak = 1'b1; end
            @(negedge clk);
            if (auto_en && rst_n) begin
                if (fft_start)  cd_f = 3;
                if (cps_start)  cd_c = 2;
                if (peak_start) cd_p = 2;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input bit stray, input int limit, output bit seen);
        logic inj;
        seen = 1'b0;
        for (int c = 0; c < limit && !seen; c++) begin
            if (stray) begin
                inj      = (phase inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7});
                start    = inj || (phase == 4'd9);
                man_cps  = inj;
                man_peak = inj;
            end
            @(negedge clk);
            if (done) seen = 1'b1;
            tick();
        end
        start = 1'b0; man_cps = 1'b0; man_peak = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int base);
        logic [4:0] exp;
        chk({tag, "_nstart"}, 32'(log_q.size() - base), 32'd24);
        for (int i = 0; i < 24 && base + i < log_q.size(); i++) begin
            exp = {tbl[i / 4], i[1:0]};
            chk({tag, "_line"}, 32'(log_q[base + i]), 32'(exp));
        end
    endtask

    task automatic check_idle_after(input string tag, input logic [15:0] cnt);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_phase_idle"}, 32'(phase), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(cnt));
    endtask

    initial begin
        bit seen;
        int base, c0, p0, d0;

        // reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_fft_start", 32'(fft_start), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_no_pulse", 32'({fft_start, cps_start, peak_start, done}), 32'd0);

        // start, then reset asynchronously in the middle of A_COL
        auto_en = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        @(negedge clk);
        chk("start1_phase", 32'(phase), 32'd1);
        chk("start1_fft_start", 32'(fft_start), 32'd1);
        for (int c = 0; c < 200 && phase != 4'd2; c++) tick();
        chk("reach_acol", 32'(phase), 32'd2);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_outs", 32'({busy, fft_start, fft_col, line_idx, cps_start, peak_start, done}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // full frame with core replies after 3 cycles
        base = log_q.size(); c0 = n_cps; p0 = n_peak; d0 = n_done;
        start = 1'b1; tick(); start = 1'b0;
        @(negedge clk);
        chk("start2_phase", 32'(phase), 32'd1);
        chk("start2_fft_start", 32'(fft_start), 32'd1);
        chk("start2_line", 32'(line_idx), 32'd0);
        chk("start2_busy", 32'(busy), 32'd1);
        wait_done(1'b0, 600, seen);
        chk("frame1_seen_done", 32'(seen), 32'd1);
        check_frame("frame1", base);
        chk("frame1_cps", 32'(n_cps - c0), 32'd1);
        chk("frame1_peak", 32'(n_peak - p0), 32'd1);
        chk("frame1_done", 32'(n_done - d0), 32'd1);
        check_idle_after("frame1", 16'd1);

        // fft_done in the same cycle as fft_start is ignored
        tick();
        auto_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        man_fft = 1'b1;
        @(negedge clk);
        chk("same_cycle_start", 32'(fft_start), 32'd1);
        tick(); man_fft = 1'b0;
        @(negedge clk);
        chk("same_cycle_phase", 32'(phase), 32'd1);
        chk("same_cycle_line", 32'(line_idx), 32'd0);
        chk("same_cycle_no_restart", 32'(fft_start), 32'd0);
        tick(); man_fft = 1'b1; auto_en = 1'b1;
        tick(); man_fft = 1'b0;
        @(negedge clk);
        chk("late_done_start", 32'(fft_start), 32'd1);
        chk("late_done_line", 32'(line_idx), 32'd1);
        wait_done(1'b0, 600, seen);
        chk("frame2_seen_done", 32'(seen), 32'd1);
        check_idle_after("frame2", 16'd2);

        // stray start/cps_done/peak_done, plus start in FIN, change nothing
        tick();
        base = log_q.size(); c0 = n_cps; p0 = n_peak; d0 = n_done;
        start = 1'b1; tick(); start = 1'b0;
        wait_done(1'b1, 600, seen);
        chk("frame3_seen_done", 32'(seen), 32'd1);
        check_frame("frame3", base);
        chk("frame3_cps", 32'(n_cps - c0), 32'd1);
        chk("frame3_peak", 32'(n_peak - p0), 32'd1);
        chk("frame3_done", 32'(n_done - d0), 32'd1);
        check_idle_after("frame3", 16'd3);

`ifdef PC_WATCHDOG_EN
        // withhold fft_done in B_COL until the watchdog fires
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 300 && phase != 4'd4; c++) tick();
        chk("wd_reach_bcol", 32'(phase), 32'd4);
        auto_en = 1'b0;
        wait_done(1'b0, 1100000, seen);
        chk("wd_seen_done", 32'(seen), 32'd1);
        @(negedge clk);
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_frame_cnt", 32'(frame_cnt), 32'd3);
        auto_en = 1'b1;
`endif

        // frame_cnt wraps from 0xFFFF to 0
        tick();
        force dut.frame_q = 16'hFFFF;
        tick();
        release dut.frame_q;
        @(negedge clk);
        chk("wrap_preload", 32'(frame_cnt), 32'hFFFF);
        tick();
        start = 1'b1; tick(); start = 1'b0;
`ifdef PC_WATCHDOG_EN
        @(negedge clk);
        chk("wd_timeout_cleared", 32'(timeout), 32'd0);
`endif
        wait_done(1'b0, 600, seen);
        chk("wrap_seen_done", 32'(seen), 32'd1);
        check_idle_after("wrap", 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
